// File: rtl/dynamic_output_rr_sched_pkg.sv
// dynamic_output_rr_sched_pkg: route encodings and FSM states shared by the
// scheduler and the output datapath mux.
package dynamic_output_rr_sched_pkg;
   localparam int NUM_DYN_INPUTS = 5;
   localparam logic [2:0] ROUTE_A = 3'b000;
   localparam logic [2:0] ROUTE_B = 3'b001;
   localparam logic [2:0] ROUTE_C = 3'b010;
   localparam logic [2:0] ROUTE_D = 3'b011;
   localparam logic [2:0] ROUTE_X = 3'b100;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   function automatic logic [2:0] wrap_inc(input logic [2:0] i);
      return (i >= ROUTE_X) ? ROUTE_A : i + 3'd1;
   endfunction
endpackage

// File: rtl/dynamic_output_rr_sched_pick.sv
// dynamic_rr_pick: combinational 5-way round-robin picker starting at ptr.
module dynamic_rr_pick
   import dynamic_output_rr_sched_pkg::*;
(
   input  logic [4:0] eligible,
   input  logic [2:0] ptr,
   output logic       any,
   output logic [2:0] winner
);
   logic [2:0] w_idx;

   always_comb begin
      any    = 1'b0;
      winner = ROUTE_A;
      w_idx  = (ptr > ROUTE_X) ? ROUTE_A : ptr;
      for (int k = 0; k < NUM_DYN_INPUTS; k++) begin
         if (!any && eligible[w_idx]) begin
            any    = 1'b1;
            winner = w_idx;
         end
         w_idx = wrap_inc(w_idx);
      end
   end
endmodule

// File: rtl/dynamic_output_rr_sched.sv
// dynamic_output_rr_sched: wormhole round-robin owner of one dynamic-network
// output port, with downstream credit tracking and error flags.
module dynamic_output_rr_sched
   import dynamic_output_rr_sched_pkg::*;
#(
   parameter int CREDITS = 4,
   parameter int CW      = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          route_req_a_in,
   input  logic          route_req_b_in,
   input  logic          route_req_c_in,
   input  logic          route_req_d_in,
   input  logic          route_req_x_in,
   input  logic          valid_a_in,
   input  logic          valid_b_in,
   input  logic          valid_c_in,
   input  logic          valid_d_in,
   input  logic          valid_x_in,
   input  logic          tail_a_in,
   input  logic          tail_b_in,
   input  logic          tail_c_in,
   input  logic          tail_d_in,
   input  logic          tail_x_in,
   input  logic          yummy_in,
   output logic [2:0]    current_route,
   output logic          route_locked,
   output logic          valid_out,
   output logic          thanks_a_out,
   output logic          thanks_b_out,
   output logic          thanks_c_out,
   output logic          thanks_d_out,
   output logic          thanks_x_out,
   output logic [CW-1:0] credit_count,
   output logic          ec_wants_to_send_but_cannot,
   output logic          credit_overflow_err
);
   logic [4:0]    w_req, w_valid, w_tail, w_elig, w_elig_other, w_thanks;
   state_t        r_state, w_state_nxt;
   logic [2:0]    r_owner, w_owner_nxt, r_rr_ptr, w_rr_ptr_nxt, w_pick;
   logic          w_locked, w_send, w_arb, w_any, w_owner_back, w_sat;
   logic [CW-1:0] r_credit, w_credit_nxt;
   logic          r_ovf;

   assign w_req   = {route_req_x_in, route_req_d_in, route_req_c_in, route_req_b_in, route_req_a_in};
   assign w_valid = {valid_x_in, valid_d_in, valid_c_in, valid_b_in, valid_a_in};
   assign w_tail  = {tail_x_in, tail_d_in, tail_c_in, tail_b_in, tail_a_in};
   assign w_elig  = w_req & w_valid;

   // An out-of-range owner is treated exactly like IDLE.
   assign w_locked     = (r_state == ST_LOCKED) && (r_owner <= ROUTE_X);
   assign w_send       = w_locked && w_valid[r_owner] && (r_credit != '0);
   assign w_arb        = !w_locked || (w_send && w_tail[r_owner]);
   assign w_elig_other = w_locked ? (w_elig & ~(5'b1 << r_owner)) : w_elig;
   assign w_owner_back = w_locked && w_elig[r_owner];

   dynamic_rr_pick u_pick (
      .eligible (w_elig_other),
      .ptr      (r_rr_ptr),
      .any      (w_any),
      .winner   (w_pick)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_rr_ptr_nxt = r_rr_ptr;
      if (w_arb) begin
         if (w_any || w_owner_back) begin
            w_state_nxt  = ST_LOCKED;
            w_owner_nxt  = w_any ? w_pick : r_owner;
            w_rr_ptr_nxt = wrap_inc(w_owner_nxt);
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   assign w_sat        = yummy_in && !w_send && (r_credit == CW'(CREDITS));
   assign w_credit_nxt = w_sat ? r_credit : r_credit - CW'(w_send) + CW'(yummy_in);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_owner  <= ROUTE_A;
         r_rr_ptr <= ROUTE_A;
         r_credit <= CW'(CREDITS);
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_credit <= w_credit_nxt;
         r_ovf    <= r_ovf | w_sat;
      end
   end

   assign w_thanks                    = w_send ? (5'b1 << r_owner) : 5'b0;
   assign current_route               = w_locked ? r_owner : ROUTE_A;
   assign route_locked                = w_locked;
   assign valid_out                   = w_send;
   assign thanks_a_out                = w_thanks[0];
   assign thanks_b_out                = w_thanks[1];
   assign thanks_c_out                = w_thanks[2];
   assign thanks_d_out                = w_thanks[3];
   assign thanks_x_out                = w_thanks[4];
   assign credit_count                = r_credit;
   assign ec_wants_to_send_but_cannot = w_locked && w_valid[r_owner] && (r_credit == '0);
   assign credit_overflow_err         = r_ovf;
endmodule

// File: tb/tb_dynamic_output_rr_sched.sv
// tb_dynamic_output_rr_sched: random traffic against a behavioural model of
// the scheduler (owner, pointer, credits) with per-output comparisons.
module tb_dynamic_output_rr_sched;
   localparam int CREDITS = 4;
   localparam int CW      = 3;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] req, vld, tl;
   logic yummy;
   logic [2:0] current_route;
   logic route_locked, valid_out, ec, ovf;
   logic ta, tb, tc, td, tx;
   logic [CW-1:0] credit_count;

   int n_checks = 0;
   int n_fail   = 0;

   int m_owner, m_ptr, m_cred, m_err;

   always #5 clk = ~clk;

   dynamic_output_rr_sched #(.CREDITS(CREDITS), .CW(CW)) dut (
      .clk                         (clk),
      .reset                       (reset),
      .route_req_a_in              (req[0]),
      .route_req_b_in              (req[1]),
      .route_req_c_in              (req[2]),
      .route_req_d_in              (req[3]),
      .route_req_x_in              (req[4]),
      .valid_a_in                  (vld[0]),
      .valid_b_in                  (vld[1]),
      .valid_c_in                  (vld[2]),
      .valid_d_in                  (vld[3]),
      .valid_x_in                  (vld[4]),
      .tail_a_in                   (tl[0]),
      .tail_b_in                   (tl[1]),
      .tail_c_in                   (tl[2]),
      .tail_d_in                   (tl[3]),
      .tail_x_in                   (tl[4]),
      .yummy_in                    (yummy),
      .current_route               (current_route),
      .route_locked                (route_locked),
      .valid_out                   (valid_out),
      .thanks_a_out                (ta),
      .thanks_b_out                (tb),
      .thanks_c_out                (tc),
      .thanks_d_out                (td),
      .thanks_x_out                (tx),
      .credit_count                (credit_count),
      .ec_wants_to_send_but_cannot (ec),
      .credit_overflow_err         (ovf)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cred  = CREDITS;
      m_err   = 0;
   endtask

   initial begin
      bit locked, send, arb;
      int win, idx, yp, rp;
      logic [4:0] elig, exp_thanks;
      reset = 1'b0;
      req = '0; vld = '0; tl = '0; yummy = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         yp = (i < 1000) ? 50 : (i < 2000) ? 90 : 12;
         rp = (i < 1000) ? 60 : 35;
         reset = ($urandom_range(0, 149) != 0);
         for (int j = 0; j < 5; j++) begin
            req[j] = ($urandom_range(0, 99) < rp);
            vld[j] = ($urandom_range(0, 99) < 80);
            tl[j]  = ($urandom_range(0, 99) < 35);
         end
         yummy = ($urandom_range(0, 99) < yp);
         #1;
         locked     = (m_owner >= 0);
         send       = locked && vld[m_owner] && (m_cred > 0);
         exp_thanks = send ? 5'(1 << m_owner) : 5'd0;
         check("current_route", 8'(current_route), locked ? 8'(m_owner) : 8'd0);
         check("route_locked", 8'(route_locked), 8'(locked));
         check("valid_out", 8'(valid_out), 8'(send));
         check("thanks", 8'({tx, td, tc, tb, ta}), 8'(exp_thanks));
         check("credit_count", 8'(credit_count), 8'(m_cred));
         check("ec_stall", 8'(ec), 8'(locked && vld[m_owner] && m_cred == 0));
         check("overflow_err", 8'(ovf), 8'(m_err));
         if (!reset) begin
            model_reset();
         end else begin
            elig = req & vld;
            arb  = !locked || (send && tl[m_owner]);
            if (arb) begin
               win = -1;
               for (int k = 0; k < 5; k++) begin
                  idx = (m_ptr + k) % 5;
                  if (win < 0 && elig[idx] && !(locked && idx == m_owner)) win = idx;
               end
               if (win < 0 && locked && elig[m_owner]) win = m_owner;
               if (win >= 0) begin
                  m_owner = win;
                  m_ptr   = (win + 1) % 5;
               end else begin
                  m_owner = -1;
               end
            end
            if (yummy && !send && m_cred == CREDITS) m_err = 1;
            else m_cred = m_cred - int'(send) + int'(yummy);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      req = '0; yummy = 1'b0;
      #1;
      check("post_reset_route", 8'(current_route), 8'd0);
      check("post_reset_credit", 8'(credit_count), 8'(CREDITS));
      check("post_reset_err", 8'(ovf), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dynamic_output_rr_sched.md
Name: dynamic_output_rr_sched

Overview:
- Wormhole route scheduler for one dynamic-network output port.
- Shares the port between five input requesters (a, b, c, d, x) using round-robin arbitration.
- Once a requester wins, it holds the port until its tail flit has gone out.
- Counts downstream buffer credits (yummy returns) and drives current_route to the output data mux.
- Returns thanks to the selected input and flags stall and credit-protocol errors.

Parameters:
- CREDITS, 4: downstream buffer depth; the credit counter resets to this value.
- CW, 3: credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk, input, 1: port clock.
- reset, input, 1: synchronous, active-low reset (asserted when 0, sampled on rising clk).
- route_req_{a,b,c,d,x}_in, input, 1 each: head flit of a packet is present and requests this port.
- valid_{a,b,c,d,x}_in, input, 1 each: input FIFO has a flit available.
- tail_{a,b,c,d,x}_in, input, 1 each: the current flit of that input is the tail.
- yummy_in, input, 1: downstream freed one buffer entry (one credit returned).
- current_route, output, 3: selected input; A=000, B=001, C=010, D=011, X=100.
- route_locked, output, 1: a packet currently owns the port.
- valid_out, output, 1: a flit leaves this cycle.
- thanks_{a,b,c,d,x}_out, output, 1 each: dequeue pulse to the selected input.
- credit_count, output, CW: credits currently available.
- ec_wants_to_send_but_cannot, output, 1: locked, flit valid, zero credits.
- credit_overflow_err, output, 1: sticky; set when a yummy arrives while already at CREDITS.

Behaviour:

States:
- IDLE: no owner.
- LOCKED: owner held in a register, current_route = owner.

Request and send qualification:
- Request i is eligible when route_req_i & valid_i.
- send = LOCKED & valid_owner & (credit_count != 0).
- valid_out = send.
- thanks_owner = send; every other thanks output is 0.
- All of these are combinational from the registered state and the current inputs.

Arbitration:
- Occurs in IDLE, and also in LOCKED on a cycle where send & tail_owner (back-to-back handoff with no bubble).
- Search order starts at rr_ptr and wraps a, b, c, d, x, a, ...
- The first eligible input wins.
- The winner is registered; it is LOCKED from the next cycle.
- rr_ptr is set to (winner + 1) mod 5.
- In the handoff case, the outgoing owner is eligible only if no other input is eligible.
- If nothing is eligible, the next state is IDLE and rr_ptr is unchanged.
- Requests from non-owners are ignored while LOCKED, except on the handoff cycle.

Packet release:
- A tail flit sent returns the block to IDLE, or hands off as above.
- A one-flit packet (head and tail together) is granted in cycle N and sent and released in cycle N+1.
- Grant-to-first-flit latency is 1 cycle.

Credits:
- Next value = credit_count - send + yummy_in.
- A simultaneous send and yummy leaves the count unchanged.
- A yummy at credit_count == CREDITS with no send saturates the count and sets credit_overflow_err.
- No send is possible at 0 credits; the owner stalls and ec_wants_to_send_but_cannot = 1.

Idle outputs:
- current_route = 000, route_locked = 0, valid_out = 0, all thanks = 0.

Reset (including mid-packet):
- State IDLE, rr_ptr = 0 (a), credit_count = CREDITS, credit_overflow_err = 0.
- All outputs are 0 except credit_count.
- A partially sent packet is abandoned; clearing the upstream FIFOs on the same reset is the responsibility of the enclosing top.

Invalid input:
- An owner register value above 100 is unreachable; it decodes as IDLE.

Decomposition:
- Shared include: ROUTE_A through ROUTE_X encodings and NUM_DYN_INPUTS = 5, shared with the output datapath mux.
- Sub-module dynamic_rr_pick: purely combinational 5-way round-robin picker.
  - Inputs: eligible[4:0], ptr[2:0].
  - Outputs: any, winner[2:0].
- The sequential FSM, rr_ptr and credit counter stay in dynamic_output_rr_sched.

Test Plan:
1. Reset low 2 cycles, then high; only a is eligible, 3-flit packet, tail on flit 3 → grant next cycle, current_route=000, valid_out high 3 cycles, thanks_a pulses 3 times, then IDLE; rr_ptr=1, credit_count=1 with no yummy.
2. a, c and x all eligible continuously with 1-flit packets, rr_ptr=0, credits refilled by yummy → service order a, c, x, a, c, ...; handoff cycles show valid_out continuously high.
3. CREDITS=4, owner b, 6-flit packet, no yummy → 4 flits sent; ec_wants_to_send_but_cannot=1 with credit_count=0; one yummy → next flit sent on the same cycle the credit appears; stall resumes.
4. Send and yummy in the same cycle at credit_count=2 → credit_count stays 2; yummy at 4 with no send → count stays 4 and credit_overflow_err latches 1 until reset.
5. d locked mid-packet, reset low for 1 cycle → next cycle IDLE, valid_out=0, thanks_d=0, credit_count=4, rr_ptr=a.
6. Owner x sends its tail while only x is eligible again → x regranted with no bubble; if b is also eligible, b wins instead.
